// File: rtl/timer_share_ctrl.sv
// timer_share_ctrl
//   Shares one delay timer among N requester FSMs. Requests are latched in a
//   pending vector, one owner is picked round-robin, the shared down-counter
//   runs for that owner, and READY is returned to that owner only.
//
// Ports
//   CLK      : clock, rising edge
//   N_RESET  : asynchronous active-low reset
//   START    : per-requester start pulse
//   RESET    : per-requester release / abort (high while requester idle)
//   READY    : per-requester timer-expired flag (one-hot or zero)
//   GRANT    : one-hot owner of the timer, zero when unowned
//   BUSY     : timer owned (COUNT or DONE)
//   OWNER    : index of current / last owner
module timer_share_ctrl #(
  parameter int N     = 4,
  parameter int DELAY = 8
) (
  input  logic                 CLK,
  input  logic                 N_RESET,
  input  logic [N-1:0]         START,
  input  logic [N-1:0]         RESET,
  output logic [N-1:0]         READY,
  output logic [N-1:0]         GRANT,
  output logic                 BUSY,
  output logic [$clog2(N)-1:0] OWNER
);

  localparam int CW    = $clog2(DELAY + 1);
  localparam int OWN_W = $clog2(N);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_COUNT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  state_t             state_reg, state_next;
  logic [N-1:0]       pending_reg, pending_next;
  logic [CW-1:0]      cnt_reg, cnt_next;
  logic [OWN_W-1:0]   owner_reg, owner_next;
  logic [OWN_W-1:0]   last_reg, last_next;

  logic               pick_found;
  logic [OWN_W-1:0]   pick_idx;
  logic [N-1:0]       owner_onehot;

  // Pending latch: START wins over RESET. The owner keeps its pending bit
  // while it holds the timer, so a repeated START from the owner changes
  // nothing; the owner's own RESET on release/abort clears the bit.
  for (genvar gi = 0; gi < N; gi++) begin : g_pending
    assign pending_next[gi] = START[gi] ? 1'b1 :
                              (RESET[gi] ? 1'b0 : pending_reg[gi]);
  end

  // Round-robin pick: first pending index searching from last+1 modulo N.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 1; k <= N; k++) begin
      if (!pick_found && pending_reg[(int'(last_reg) + k) % N]) begin
        pick_found = 1'b1;
        pick_idx   = OWN_W'((int'(last_reg) + k) % N);
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    owner_next = owner_reg;
    last_next  = last_reg;
    case (state_reg)
      ST_IDLE: begin
        if (pick_found) begin
          owner_next = pick_idx;
          cnt_next   = CW'(DELAY - 1);
          state_next = ST_COUNT;
        end
      end
      ST_COUNT: begin
        if (RESET[owner_reg]) begin
          // Abort: owner gives up before expiry.
          state_next = ST_IDLE;
          last_next  = owner_reg;
        end else if (cnt_reg == '0) begin
          state_next = ST_DONE;
        end else begin
          cnt_next = cnt_reg - CW'(1);
        end
      end
      ST_DONE: begin
        if (RESET[owner_reg]) begin
          state_next = ST_IDLE;
          last_next  = owner_reg;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge N_RESET) begin
    if (!N_RESET) begin
      state_reg   <= ST_IDLE;
      pending_reg <= '0;
      cnt_reg     <= '0;
      owner_reg   <= '0;
      last_reg    <= OWN_W'(N - 1);
    end else begin
      state_reg   <= state_next;
      pending_reg <= pending_next;
      cnt_reg     <= cnt_next;
      owner_reg   <= owner_next;
      last_reg    <= last_next;
    end
  end

  // Moore outputs, decoded from registered state and owner only.
  assign owner_onehot = N'(1) << owner_reg;

  always_comb begin
    GRANT = '0;
    READY = '0;
    BUSY  = 1'b0;
    case (state_reg)
      ST_COUNT: begin
        GRANT = owner_onehot;
        BUSY  = 1'b1;
      end
      ST_DONE: begin
        GRANT = owner_onehot;
        READY = owner_onehot;
        BUSY  = 1'b1;
      end
      default: ;
    endcase
  end

  assign OWNER = owner_reg;

endmodule

// File: tb/tb_timer_share_ctrl.sv
// tb_timer_share_ctrl
//   Directed bench for timer_share_ctrl with N=4, DELAY=4. Inputs change 1
//   time unit after the rising edge and outputs are sampled there as well.
//   "Cycle k" is the interval after the k-th edge counted from stimulus start.
module tb_timer_share_ctrl;

  localparam int N     = 4;
  localparam int DELAY = 4;

  logic       CLK;
  logic       N_RESET;
  logic [3:0] START;
  logic [3:0] RESET;
  logic [3:0] READY;
  logic [3:0] GRANT;
  logic       BUSY;
  logic [1:0] OWNER;

  int checks;
  int failures;

  timer_share_ctrl #(.N(N), .DELAY(DELAY)) dut (
    .CLK     (CLK),
    .N_RESET (N_RESET),
    .START   (START),
    .RESET   (RESET),
    .READY   (READY),
    .GRANT   (GRANT),
    .BUSY    (BUSY),
    .OWNER   (OWNER)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog expired got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    N_RESET = 1'b0;
    START   = 4'b0000;
    RESET   = 4'b1111;
    tick();
    tick();
    N_RESET = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    N_RESET = 1'b0;
    START   = 4'b0000;
    RESET   = 4'b1111;
    #1;
    checks++; if (GRANT !== 4'b0000) begin failures++; $display("FAIL reset_grant got=%b exp=%b", GRANT, 4'b0000); end
    checks++; if (READY !== 4'b0000) begin failures++; $display("FAIL reset_ready got=%b exp=%b", READY, 4'b0000); end
    checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", BUSY); end
    checks++; if (OWNER !== 2'd0) begin failures++; $display("FAIL reset_owner got=%0d exp=0", OWNER); end
    tick();
    N_RESET = 1'b1;
    tick();
    tick();
    checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL reset_idle_busy got=%b exp=0", BUSY); end
    $display("test_reset done");
  endtask

  task automatic test_single();
    logic [3:0] exp_ready;
    do_reset();
    START[1] = 1'b1; RESET[1] = 1'b0;
    tick();                                   // cycle 1: pending only
    START[1] = 1'b0;
    checks++; if (GRANT !== 4'b0000) begin failures++; $display("FAIL single_c1_grant got=%b exp=%b", GRANT, 4'b0000); end
    tick();                                   // cycle 2
    for (int c = 2; c <= 8; c++) begin
      exp_ready = (c >= 6) ? 4'b0010 : 4'b0000;
      checks++; if (GRANT !== 4'b0010) begin failures++; $display("FAIL single_grant c=%0d got=%b exp=%b", c, GRANT, 4'b0010); end
      checks++; if (READY !== exp_ready) begin failures++; $display("FAIL single_ready c=%0d got=%b exp=%b", c, READY, exp_ready); end
      checks++; if (OWNER !== 2'd1) begin failures++; $display("FAIL single_owner c=%0d got=%0d exp=1", c, OWNER); end
      if (c == 8) RESET[1] = 1'b1;
      tick();
    end
    // cycle 9
    checks++; if ({GRANT, READY, BUSY} !== 9'd0) begin failures++; $display("FAIL single_release got=%b/%b/%b exp=0/0/0", GRANT, READY, BUSY); end
    $display("test_single done");
  endtask

  task automatic test_two_same();
    do_reset();
    START[0] = 1'b1; START[2] = 1'b1; RESET[0] = 1'b0; RESET[2] = 1'b0;
    tick();
    START = 4'b0000;
    tick();                                   // cycle 2
    checks++; if (GRANT !== 4'b0001) begin failures++; $display("FAIL two_first_grant got=%b exp=%b", GRANT, 4'b0001); end
    checks++; if (OWNER !== 2'd0) begin failures++; $display("FAIL two_first_owner got=%0d exp=0", OWNER); end
    tick(); tick(); tick(); tick();           // cycle 6
    checks++; if (READY !== 4'b0001) begin failures++; $display("FAIL two_first_ready got=%b exp=%b", READY, 4'b0001); end
    RESET[0] = 1'b1;
    tick();                                   // cycle 7: one idle cycle
    checks++; if ({GRANT, BUSY} !== 5'd0) begin failures++; $display("FAIL two_gap got=%b/%b exp=0/0", GRANT, BUSY); end
    tick();                                   // cycle 8
    checks++; if (GRANT !== 4'b0100) begin failures++; $display("FAIL two_second_grant got=%b exp=%b", GRANT, 4'b0100); end
    checks++; if (OWNER !== 2'd2) begin failures++; $display("FAIL two_second_owner got=%0d exp=2", OWNER); end
    checks++; if (READY !== 4'b0000) begin failures++; $display("FAIL two_second_ready_early got=%b exp=%b", READY, 4'b0000); end
    tick(); tick(); tick(); tick();           // cycle 12
    checks++; if (READY !== 4'b0100) begin failures++; $display("FAIL two_second_ready got=%b exp=%b", READY, 4'b0100); end
    RESET[2] = 1'b1;
    tick();
    checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL two_release_busy got=%b exp=0", BUSY); end
    $display("test_two_same done");
  endtask

  task automatic test_abort();
    do_reset();
    START[3] = 1'b1; RESET[3] = 1'b0;
    tick();
    START = 4'b0000;
    tick();                                   // cycle 2: owner 3, cnt=3
    checks++; if (GRANT !== 4'b1000) begin failures++; $display("FAIL abort_grant got=%b exp=%b", GRANT, 4'b1000); end
    START[0] = 1'b1; START[1] = 1'b1; RESET[0] = 1'b0; RESET[1] = 1'b0;
    tick();                                   // cycle 3: cnt=2
    START = 4'b0000;
    checks++; if (READY !== 4'b0000) begin failures++; $display("FAIL abort_ready_c3 got=%b exp=%b", READY, 4'b0000); end
    checks++; if (GRANT !== 4'b1000) begin failures++; $display("FAIL abort_grant_c3 got=%b exp=%b", GRANT, 4'b1000); end
    RESET[3] = 1'b1;
    tick();                                   // cycle 4: idle
    checks++; if ({GRANT, READY, BUSY} !== 9'd0) begin failures++; $display("FAIL abort_idle got=%b/%b/%b exp=0/0/0", GRANT, READY, BUSY); end
    tick();                                   // cycle 5: wrap to 0
    checks++; if (GRANT !== 4'b0001) begin failures++; $display("FAIL abort_next_grant got=%b exp=%b", GRANT, 4'b0001); end
    checks++; if (OWNER !== 2'd0) begin failures++; $display("FAIL abort_next_owner got=%0d exp=0", OWNER); end
    RESET[0] = 1'b1;
    tick();                                   // cycle 6: idle
    tick();                                   // cycle 7: owner 1
    checks++; if (GRANT !== 4'b0010) begin failures++; $display("FAIL abort_third_grant got=%b exp=%b", GRANT, 4'b0010); end
    RESET[1] = 1'b1;
    tick(); tick(); tick();
    checks++; if ({GRANT, BUSY} !== 5'd0) begin failures++; $display("FAIL abort_no_regrant3 got=%b/%b exp=0/0", GRANT, BUSY); end
    $display("test_abort done");
  endtask

  task automatic test_pending_cancel();
    logic seen1;
    seen1 = 1'b0;
    do_reset();
    START[0] = 1'b1; RESET[0] = 1'b0;
    tick();
    START = 4'b0000;
    tick();                                   // cycle 2: owner 0
    START[1] = 1'b1; RESET[1] = 1'b0;
    tick();                                   // cycle 3: pending[1]
    START[1] = 1'b0; RESET[1] = 1'b1;         // cancel
    for (int c = 3; c <= 6; c++) begin
      checks++; if (GRANT !== 4'b0001) begin failures++; $display("FAIL cancel_grant c=%0d got=%b exp=%b", c, GRANT, 4'b0001); end
      if (c < 6) tick();
    end
    checks++; if (READY !== 4'b0001) begin failures++; $display("FAIL cancel_ready got=%b exp=%b", READY, 4'b0001); end
    RESET[0] = 1'b1;
    for (int c = 7; c <= 10; c++) begin
      tick();
      if (GRANT[1] || BUSY) seen1 = 1'b1;
    end
    checks++; if (seen1 !== 1'b0) begin failures++; $display("FAIL cancel_no_grant1 got=%b exp=0", seen1); end
    $display("test_pending_cancel done");
  endtask

  task automatic test_async_reset();
    logic any_busy;
    any_busy = 1'b0;
    do_reset();
    START = 4'b0111; RESET = 4'b1000;
    tick();
    START = 4'b0000;
    tick();                                   // cycle 2: owner 0
    checks++; if (BUSY !== 1'b1) begin failures++; $display("FAIL async_busy_before got=%b exp=1", BUSY); end
    tick();                                   // cycle 3, mid-count
    #2 N_RESET = 1'b0;
    #1;
    checks++; if ({GRANT, READY, BUSY} !== 9'd0) begin failures++; $display("FAIL async_outputs got=%b/%b/%b exp=0/0/0", GRANT, READY, BUSY); end
    #2 N_RESET = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (BUSY || (GRANT != 4'b0000)) any_busy = 1'b1;
    end
    checks++; if (any_busy !== 1'b0) begin failures++; $display("FAIL async_pending_lost got=%b exp=0", any_busy); end
    RESET = 4'b1011;
    START[2] = 1'b1;
    tick();
    START = 4'b0000;
    tick();
    checks++; if (GRANT !== 4'b0100) begin failures++; $display("FAIL async_new_grant got=%b exp=%b", GRANT, 4'b0100); end
    RESET = 4'b1111;
    tick();
    $display("test_async_reset done");
  endtask

  task automatic test_fairness();
    logic [3:0] oh;
    int         exp;
    do_reset();
    START = 4'b1111; RESET = 4'b0000;
    tick();
    START = 4'b0000;
    tick();                                   // first grant
    for (int g = 0; g < 12; g++) begin
      exp = g % 4;
      oh  = 4'b0001 << exp;
      checks++; if (OWNER !== 2'(exp)) begin failures++; $display("FAIL fair_owner g=%0d got=%0d exp=%0d", g, OWNER, exp); end
      checks++; if (GRANT !== oh) begin failures++; $display("FAIL fair_grant g=%0d got=%b exp=%b", g, GRANT, oh); end
      START[exp] = 1'b1;                      // repeated START while owning
      tick();
      START[exp] = 1'b0;
      tick(); tick();                         // grant + 3: cnt=0
      checks++; if (READY !== 4'b0000) begin failures++; $display("FAIL fair_ready_early g=%0d got=%b exp=%b", g, READY, 4'b0000); end
      tick();                                 // grant + 4: done
      checks++; if (READY !== oh) begin failures++; $display("FAIL fair_ready g=%0d got=%b exp=%b", g, READY, oh); end
      RESET[exp] = 1'b1;
      tick();                                 // idle gap
      checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL fair_gap g=%0d got=%b exp=0", g, BUSY); end
      START[exp] = 1'b1; RESET[exp] = 1'b0;   // re-request right after release
      tick();
      START[exp] = 1'b0;
      $display("fair grant %0d owner %0d", g, exp);
    end
    $display("test_fairness done");
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    N_RESET  = 1'b0;
    START    = 4'b0000;
    RESET    = 4'b1111;
    tick();
    test_reset();
    test_single();
    test_two_same();
    test_abort();
    test_pending_cancel();
    test_async_reset();
    test_fairness();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/timer_share_ctrl.md
Name: timer_share_ctrl

Overview:
- Controller that shares one delay timer among N requester Moore FSMs of the linked-state-machine type.
- Each requester signals START (one-cycle pulse) and RESET (high while idle or abandoning), and waits for READY.
- The block latches requests, picks one owner round-robin, runs the shared down-counter for that owner, and returns READY to that owner only.
- Sits between the requester FSMs and the timing resource; it replaces per-requester private timers.

Parameters:
N, 4, number of requesters (2..8)
DELAY, 8, timer length in clock cycles from grant to READY (>=1)
CW, $clog2(DELAY+1), counter width (derived, not overridden)

Ports:
CLK  input  1  clock, rising edge
N_RESET  input  1  asynchronous active-low reset
START  input  N  per-requester start pulse (requester in ST state)
RESET  input  N  per-requester timer-reset/release (requester IDLE or abort)
READY  output  N  per-requester timer-expired flag, one-hot or zero
GRANT  output  N  one-hot owner of the timer, zero when unowned
BUSY  output  1  timer owned (state COUNT or DONE)
OWNER  output  $clog2(N)  index of current/last owner

Behaviour:
- Reset (N_RESET=0, asynchronous): state=IDLE, pending=0, cnt=0, OWNER=0, last pointer=N-1 (requester 0 has first priority), READY=0, GRANT=0, BUSY=0.
- Pending latch, per bit i, registered:
  - START[i]=1 sets pending[i].
  - Else RESET[i]=1 clears pending[i].
  - START wins when both are high.
  - START from a requester that is already pending or owning: no effect (no restart, no double entry).
- States and transitions:
  - IDLE:
    - If pending!=0, choose the first pending index searching from last+1 modulo N.
    - Load OWNER, load cnt=DELAY-1, go to COUNT.
    - Else stay in IDLE.
  - COUNT:
    - If RESET[OWNER]=1, go to IDLE (abort), clear pending[OWNER], set last=OWNER.
    - Else if cnt==0, go to DONE.
    - Else cnt=cnt-1.
  - DONE:
    - Hold until RESET[OWNER]=1.
    - Then go to IDLE, clear pending[OWNER], set last=OWNER.
- Outputs (Moore, decoded from registered state/OWNER only, no input-to-output paths):
  - IDLE: GRANT=0, READY=0, BUSY=0.
  - COUNT: GRANT=onehot(OWNER), READY=0, BUSY=1.
  - DONE: GRANT=onehot(OWNER), READY=onehot(OWNER), BUSY=1.
- Latency:
  - START[i] at edge t sets pending at t+1.
  - Grant (COUNT) from t+2.
  - READY[i] from t+2+DELAY.
  - The minimum IDLE gap between owners is exactly one cycle.
- Non-owner RESET bits: affect only their own pending bits; never the running count.
- Requests arriving during COUNT/DONE: latched; served after the current owner releases, in round-robin order.
- Fairness: with all N pending continuously, grants rotate i, i+1, ..., with no requester granted twice before every other pending one is served.
- Illegal or unused state encoding: return to IDLE next cycle with outputs as IDLE.
- N_RESET asserted mid-COUNT or mid-DONE: immediate return to reset values; all pending requests are lost.

Test Plan:
- DELAY=4, N=4:
  - START[1] pulse at cycle 0, RESET[1]=0 afterwards -> GRANT=4'b0010 at cycles 2-5, READY=4'b0010 from cycle 6.
  - RESET[1]=1 at cycle 8 -> IDLE at cycle 9, all outputs 0.
- START[0] and START[2] same cycle -> requester 0 served first (DELAY cycles, READY, release), then requester 2 granted one cycle after release, OWNER=2.
- Abort: requester 3 owning in COUNT with cnt=2, RESET[3]=1 -> IDLE next cycle, READY never asserted, pending[3]=0, next grant goes to the lowest pending index after 3 (wrap to 0).
- Pending cancel: requester 1 pending behind owner 0, RESET[1]=1 for one cycle -> pending[1] cleared, requester 1 never granted, BUSY drops after owner 0 releases.
- N_RESET low for one cycle mid-COUNT with two pending -> GRANT=READY=0, BUSY=0 asynchronously; after release, no grant until a new START.
- All four requesters re-pulse START immediately after each release for 12 grants -> OWNER sequence 0,1,2,3,0,1,2,3,...; repeated START to the current owner during COUNT does not restart cnt.
